// File: rtl/psum_accumulator_pkg.sv
// Shared types and constants for the partial-sum accumulator and its
// adder_tree neighbour.
package psum_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DEFAULT_TREE_LATENCY = 7;
  localparam int DEFAULT_ACC_WIDTH    = 32;

  // Saturation limits for a w-bit signed accumulator, truncated by the caller.
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction

endpackage

// File: rtl/psum_accumulator_if.sv
// Data-path bundle: tree-side issue strobe and sum, plus the result stream
// handshake.
interface psum_accumulator_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32
);
  logic                  issue_valid;
  logic [DATA_WIDTH-1:0] tree_sum;
  logic                  out_valid;
  logic [ACC_WIDTH-1:0]  out_data;
  logic                  out_ready;

  modport master (
    output issue_valid, tree_sum, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  issue_valid, tree_sum, out_ready,
    output out_valid, out_data
  );
endinterface

// File: rtl/psum_fifo.sv
// Small synchronous FIFO with a combinational head; a push into a full FIFO
// is taken only when a pop frees a slot in the same cycle.
module psum_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_reg == (AW + 1)'(DEPTH));
  assign empty    = (count_reg == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr_reg] <= push_data;
        wr_ptr_reg      <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW + 1)'(1);
        2'b01:   count_reg <= count_reg - (AW + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// Aligns issue strobes to the adder_tree latency, accumulates num_tiles tree
// sums per element with signed saturation, and buffers finished elements.
module psum_accumulator
  import psum_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int ACC_WIDTH     = DEFAULT_ACC_WIDTH,
  parameter int TREE_LATENCY  = DEFAULT_TREE_LATENCY,
  parameter int CNT_WIDTH     = 8,
  parameter int OUT_CNT_WIDTH = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [CNT_WIDTH-1:0]     num_tiles,
  input  logic [OUT_CNT_WIDTH-1:0] num_outputs,
  psum_accumulator_if.slave        bus,
  output logic                     busy,
  output logic                     done,
  output logic                     sat_flag,
  output logic                     drop_flag
);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH));
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH));

  state_e                   state_reg, state_next;
  logic                     valid_sr [TREE_LATENCY];
  logic [CNT_WIDTH-1:0]     tiles_reg;
  logic [OUT_CNT_WIDTH-1:0] outputs_reg;
  logic [CNT_WIDTH-1:0]     tile_cnt_reg;
  logic [OUT_CNT_WIDTH-1:0] out_cnt_reg;
  logic [ACC_WIDTH-1:0]     acc_reg;
  logic                     sat_flag_reg;
  logic                     drop_flag_reg;

  logic                     sum_valid;
  logic [ACC_WIDTH-1:0]     ext;
  logic [ACC_WIDTH:0]       sum_wide;
  logic                     ovf;
  logic [ACC_WIDTH-1:0]     sat_sum;
  logic                     first_tile;
  logic                     last_tile;
  logic [ACC_WIDTH-1:0]     acc_next;
  logic                     accum_fire;
  logic                     push;
  logic                     push_lost;
  logic                     stray_valid;
  logic                     start_ok;
  logic                     job_last;
  logic [OUT_CNT_WIDTH-1:0] out_cnt_inc;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [ACC_WIDTH-1:0]     head_data;

  // Issue strobe delayed to line up with the matching tree_sum.
  for (genvar gi = 0; gi < TREE_LATENCY; gi++) begin : g_valid_sr
    if (gi == 0) begin : g_head
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) valid_sr[gi] <= 1'b0;
        else        valid_sr[gi] <= bus.issue_valid;
      end
    end else begin : g_tail
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) valid_sr[gi] <= 1'b0;
        else        valid_sr[gi] <= valid_sr[gi-1];
      end
    end
  end

  assign sum_valid   = valid_sr[TREE_LATENCY-1];
  assign ext         = {{(ACC_WIDTH-DATA_WIDTH){bus.tree_sum[DATA_WIDTH-1]}}, bus.tree_sum};
  assign sum_wide    = {acc_reg[ACC_WIDTH-1], acc_reg} + {ext[ACC_WIDTH-1], ext};
  assign ovf         = sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1];
  assign sat_sum     = ovf ? (sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : sum_wide[ACC_WIDTH-1:0];
  assign first_tile  = (tile_cnt_reg == '0);
  assign last_tile   = (tile_cnt_reg == tiles_reg - CNT_WIDTH'(1));
  assign acc_next    = first_tile ? ext : sat_sum;
  assign accum_fire  = (state_reg == ACCUM) && sum_valid;
  assign push        = accum_fire && last_tile;
  // A full FIFO always presents out_valid, so out_ready alone decides the pop.
  assign push_lost   = push && fifo_full && !bus.out_ready;
  assign stray_valid = sum_valid && (state_reg != ACCUM);
  assign start_ok    = (state_reg == IDLE) && start;
  assign out_cnt_inc = out_cnt_reg + OUT_CNT_WIDTH'(1);
  assign job_last    = push && (out_cnt_inc == outputs_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = (num_outputs == '0) ? DONE : ACCUM;
      ACCUM:   if (job_last) state_next = FLUSH;
      FLUSH:   if (fifo_empty) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == ACCUM) || (state_reg == FLUSH);
    done = (state_reg == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tiles_reg     <= CNT_WIDTH'(1);
      outputs_reg   <= '0;
      tile_cnt_reg  <= '0;
      out_cnt_reg   <= '0;
      acc_reg       <= '0;
      sat_flag_reg  <= 1'b0;
      drop_flag_reg <= 1'b0;
    end else begin
      if (start_ok) begin
        tiles_reg    <= (num_tiles == '0) ? CNT_WIDTH'(1) : num_tiles;
        outputs_reg  <= num_outputs;
        tile_cnt_reg <= '0;
        out_cnt_reg  <= '0;
      end else if (accum_fire) begin
        acc_reg <= acc_next;
        if (last_tile) begin
          tile_cnt_reg <= '0;
          out_cnt_reg  <= out_cnt_inc;
        end else begin
          tile_cnt_reg <= tile_cnt_reg + CNT_WIDTH'(1);
        end
      end
      sat_flag_reg  <= (sat_flag_reg && !start_ok) || (accum_fire && !first_tile && ovf);
      drop_flag_reg <= (drop_flag_reg && !start_ok) || stray_valid || push_lost;
    end
  end

  assign sat_flag  = sat_flag_reg;
  assign drop_flag = drop_flag_reg;

  psum_fifo #(
    .WIDTH (ACC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (acc_next),
    .pop       (bus.out_ready),
    .pop_data  (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = head_data;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: table of small jobs plus hand-written
// sequences for backpressure, saturation at a narrow width, and mid-job reset.
module tb_psum_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  num_tiles = 8'd0;
  logic [15:0] num_outputs = 16'd0;
  logic        busy, done, sat_flag, drop_flag;
  logic        out_ready = 1'b0;

  logic        start17 = 1'b0;
  logic [7:0]  num_tiles17 = 8'd4;
  logic [15:0] num_outputs17 = 16'd1;
  logic        busy17, done17, sat_flag17, drop_flag17;

  logic        pe_valid = 1'b0;
  logic [15:0] pe_data = 16'd0;
  logic [15:0] tree_pipe [7];

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          done_cnt = 0;
  bit          rand_ready = 1'b0;
  logic [31:0] obs_data [$];
  int          obs_cyc [$];
  int          issue_cyc [$];

  psum_accumulator_if #(.DATA_WIDTH(16), .ACC_WIDTH(32)) bus_if ();
  psum_accumulator_if #(.DATA_WIDTH(16), .ACC_WIDTH(17)) bus17 ();

  assign bus_if.issue_valid = pe_valid;
  assign bus_if.tree_sum    = tree_pipe[6];
  assign bus_if.out_ready   = out_ready;
  assign bus17.issue_valid  = pe_valid;
  assign bus17.tree_sum     = tree_pipe[6];
  assign bus17.out_ready    = 1'b1;

  psum_accumulator #(.ACC_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_tiles(num_tiles),
    .num_outputs(num_outputs), .bus(bus_if), .busy(busy), .done(done),
    .sat_flag(sat_flag), .drop_flag(drop_flag)
  );

  psum_accumulator #(.ACC_WIDTH(17)) dut17 (
    .clk(clk), .rst_n(rst_n), .start(start17), .num_tiles(num_tiles17),
    .num_outputs(num_outputs17), .bus(bus17), .busy(busy17), .done(done17),
    .sat_flag(sat_flag17), .drop_flag(drop_flag17)
  );

  always #5 clk = ~clk;

  // Stand-in for the adder_tree: a 7-cycle delay of the presented value.
  initial for (int i = 0; i < 7; i++) tree_pipe[i] = 16'd0;
  always @(posedge clk) begin
    tree_pipe[0] <= pe_data;
    for (int i = 1; i < 7; i++) tree_pipe[i] <= tree_pipe[i-1];
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_if.out_valid && out_ready) begin
        obs_data.push_back(bus_if.out_data);
        obs_cyc.push_back(cyc);
      end
      if (done) done_cnt++;
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  typedef struct packed {
    logic [7:0]         tiles;
    logic [15:0]        outs;
    int                 n_sums;
    logic [0:7][15:0]   sums;
    int                 n_exp;
    logic [0:3][31:0]   exp;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] t, input logic [15:0] o);
    start = 1'b1;
    num_tiles = t;
    num_outputs = o;
    tick();
    start = 1'b0;
  endtask

  task automatic issue(input logic [15:0] d);
    issue_cyc.push_back(cyc);
    pe_valid = 1'b1;
    pe_data = d;
    tick();
    pe_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) tick();
    chk(name, 32'(done_cnt != 0), 32'd1);
  endtask

  task automatic clear_obs();
    obs_data.delete();
    obs_cyc.delete();
    issue_cyc.delete();
    done_cnt = 0;
  endtask

  initial begin
    logic [31:0] v17;
    logic [15:0] a, b;
    logic [31:0] exp_q [$];
    int teff;

    vecs[0] = '{tiles: 8'd1, outs: 16'd3, n_sums: 3,
                sums: {16'h0005, 16'hFFFF, 16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                n_exp: 3, exp: {32'h00000005, 32'hFFFFFFFF, 32'h00007FFF, 32'h0}};
    vecs[1] = '{tiles: 8'd4, outs: 16'd2, n_sums: 8,
                sums: {16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},
                n_exp: 2, exp: {32'h0000000A, 32'hFFFFFFFC, 32'h0, 32'h0}};
    vecs[2] = '{tiles: 8'd0, outs: 16'd2, n_sums: 2,
                sums: {16'h8000, 16'h0003, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                n_exp: 2, exp: {32'hFFFF8000, 32'h00000003, 32'h0, 32'h0}};
    vecs[3] = '{tiles: 8'd3, outs: 16'd1, n_sums: 3,
                sums: {16'h7FFF, 16'h7FFF, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                n_exp: 1, exp: {32'h00007FFE, 32'h0, 32'h0, 32'h0}};
    vecs[4] = '{tiles: 8'd2, outs: 16'd2, n_sums: 4,
                sums: {16'h8000, 16'h8000, 16'h0001, 16'hFFFE, 16'h0, 16'h0, 16'h0, 16'h0},
                n_exp: 2, exp: {32'hFFFF0000, 32'hFFFFFFFF, 32'h0, 32'h0}};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    chk("rst_out_data", bus_if.out_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sat", 32'(sat_flag), 32'd0);
    chk("rst_drop", 32'(drop_flag), 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    // Table-driven jobs with out_ready held high
    for (int v = 0; v < 5; v++) begin
      clear_obs();
      teff = (vecs[v].tiles == 8'd0) ? 1 : int'(vecs[v].tiles);
      do_start(vecs[v].tiles, vecs[v].outs);
      chk($sformatf("v%0d_busy", v), 32'(busy), 32'd1);
      for (int i = 0; i < vecs[v].n_sums; i++) issue(vecs[v].sums[i]);
      wait_done($sformatf("v%0d_done_seen", v), 60);
      chk($sformatf("v%0d_busy_after_done", v), 32'(busy), 32'd0);
      chk($sformatf("v%0d_done_pulse", v), 32'(done), 32'd0);
      chk($sformatf("v%0d_count", v), 32'(obs_data.size()), 32'(vecs[v].n_exp));
      for (int j = 0; j < vecs[v].n_exp; j++) begin
        if (j < obs_data.size()) begin
          chk($sformatf("v%0d_data%0d", v, j), obs_data[j], vecs[v].exp[j]);
          chk($sformatf("v%0d_lat%0d", v, j), 32'(obs_cyc[j]),
              32'(issue_cyc[(j + 1) * teff - 1] + 8));
        end
      end
      tick();
      tick();
      chk($sformatf("v%0d_done_once", v), 32'(done_cnt), 32'd1);
      chk($sformatf("v%0d_sat", v), 32'(sat_flag), 32'd0);
      chk($sformatf("v%0d_drop", v), 32'(drop_flag), 32'd0);
    end

    // 17-bit accumulator saturates on four 0x7FFF sums
    start17 = 1'b1;
    tick();
    start17 = 1'b0;
    for (int i = 0; i < 4; i++) issue(16'h7FFF);
    v17 = 32'hDEADBEEF;
    for (int i = 0; i < 20 && v17 == 32'hDEADBEEF; i++) begin
      if (bus17.out_valid) v17 = 32'(bus17.out_data);
      else tick();
    end
    chk("acc17_data", v17, 32'h0000FFFF);
    chk("acc17_sat", 32'(sat_flag17), 32'd1);
    repeat (4) tick();
    chk("acc17_idle", 32'(busy17), 32'd0);

    // FIFO overflow under stalled consumer, then drain
    clear_obs();
    out_ready = 1'b0;
    do_start(8'd1, 16'd6);
    for (int i = 0; i < 6; i++) issue(16'h0011 + 16'(i));
    repeat (10) tick();
    chk("ovf_busy_flush", 32'(busy), 32'd1);
    chk("ovf_out_valid", 32'(bus_if.out_valid), 32'd1);
    chk("ovf_head", bus_if.out_data, 32'h00000011);
    chk("ovf_drop", 32'(drop_flag), 32'd1);
    repeat (3) tick();
    chk("ovf_head_stable", bus_if.out_data, 32'h00000011);
    do_start(8'd2, 16'd1);
    chk("ovf_start_ignored_drop", 32'(drop_flag), 32'd1);
    chk("ovf_start_ignored_busy", 32'(busy), 32'd1);
    chk("ovf_no_early_done", 32'(done_cnt), 32'd0);
    out_ready = 1'b1;
    wait_done("ovf_done_seen", 30);
    chk("ovf_count", 32'(obs_data.size()), 32'd4);
    for (int j = 0; j < 4; j++)
      if (j < obs_data.size())
        chk($sformatf("ovf_data%0d", j), obs_data[j], 32'h11 + 32'(j));
    tick();
    chk("ovf_done_once", 32'(done_cnt), 32'd1);

    // Back-to-back pairs with random consumer stalls
    clear_obs();
    exp_q.delete();
    do_start(8'd2, 16'd64);
    rand_ready = 1'b1;
    for (int k = 0; k < 64; k++) begin
      a = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(0, 65535));
      exp_q.push_back(32'(int'($signed(a)) + int'($signed(b))));
      issue(a);
      issue(b);
    end
    wait_done("rand_done_seen", 300);
    rand_ready = 1'b0;
    tick();
    out_ready = 1'b1;
    chk("rand_count", 32'(obs_data.size()), 32'd64);
    for (int j = 0; j < 64; j++)
      if (j < obs_data.size())
        chk($sformatf("rand_data%0d", j), obs_data[j], exp_q[j]);
    chk("rand_drop", 32'(drop_flag), 32'd0);
    chk("rand_sat", 32'(sat_flag), 32'd0);

    // num_outputs == 0 completes at once
    clear_obs();
    do_start(8'd1, 16'd0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    tick();
    chk("zero_done_end", 32'(done), 32'd0);

    // Reset mid-ACCUM with a loaded FIFO and two valids in flight
    clear_obs();
    out_ready = 1'b0;
    do_start(8'd1, 16'd4);
    issue(16'h0021);
    issue(16'h0022);
    repeat (9) tick();
    chk("mid_fifo_loaded", 32'(bus_if.out_valid), 32'd1);
    issue(16'h0023);
    issue(16'h0024);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    chk("mid_rst_out_data", bus_if.out_data, 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (12) tick();
    chk("mid_no_stale_out", 32'(obs_data.size()), 32'd0);
    chk("mid_no_stale_drop", 32'(drop_flag), 32'd0);
    chk("mid_no_done", 32'(done_cnt), 32'd0);
    do_start(8'd1, 16'd1);
    issue(16'h0042);
    wait_done("post_rst_done_seen", 30);
    chk("post_rst_count", 32'(obs_data.size()), 32'd1);
    if (obs_data.size() > 0) chk("post_rst_data", obs_data[0], 32'h00000042);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
